// File: rtl/trap_pkg.sv
// Shared constants and types for the MIPS trap controller:
// ExcCodes, SYSCALL/BREAK/ERET encodings and the FSM state enum.
package trap_pkg;

  localparam int EXC_W = 6;

  localparam logic [EXC_W-1:0] EXC_ADEL = 6'd4;
  localparam logic [EXC_W-1:0] EXC_SYS  = 6'd8;
  localparam logic [EXC_W-1:0] EXC_BP   = 6'd9;
  localparam logic [EXC_W-1:0] EXC_OV   = 6'd12;

  localparam logic [5:0]  OP_SPECIAL = 6'b000000;
  localparam logic [5:0]  FN_SYSCALL = 6'b001100;
  localparam logic [5:0]  FN_BREAK   = 6'b001101;
  localparam logic [31:0] ERET_INSTR = 32'h4200_0018;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    TRAP_FLUSH = 3'd1,
    TRAP_REDIR = 3'd2,
    ERET_FLUSH = 3'd3,
    ERET_REDIR = 3'd4
  } trap_state_e;

endpackage

// File: rtl/trap_decode.sv
// Combinational trap decode: SYSCALL/BREAK/ERET plus external flags.
// In: instr, ovf_exc, adel_exc. Out: exc_pending, exc_code, is_eret.
module trap_decode
  import trap_pkg::*;
(
  input  logic [31:0]      instr,
  input  logic             ovf_exc,
  input  logic             adel_exc,
  output logic             exc_pending,
  output logic [EXC_W-1:0] exc_code,
  output logic             is_eret
);

  logic is_special;
  logic is_sys;
  logic is_bp;

  assign is_special = (instr[31:26] == OP_SPECIAL);
  assign is_sys     = is_special && (instr[5:0] == FN_SYSCALL);
  assign is_bp      = is_special && (instr[5:0] == FN_BREAK);
  assign is_eret    = (instr == ERET_INSTR);

  assign exc_pending = adel_exc | ovf_exc | is_sys | is_bp;

  // Several sources may fire together, so this is a priority chain.
  always_comb begin
    exc_code = '0;
    if (adel_exc)
      exc_code = EXC_ADEL;
    else if (ovf_exc)
      exc_code = EXC_OV;
    else if (is_sys)
      exc_code = EXC_SYS;
    else if (is_bp)
      exc_code = EXC_BP;
  end

endmodule

// File: rtl/trap_unit.sv
// Trap controller: captures EPC/cause/BadVAddr, flushes, redirects fetch.
// Ports: instr/flags in, flush/stall/redirect handshake out, CP0 regs out.
// TRAP_COUNT_EN adds a saturating 16-bit trap_count output.
module trap_unit
  import trap_pkg::*;
#(
  parameter int              DATA_W       = 32,
  parameter int              CODE_W       = 6,
  parameter logic [DATA_W-1:0] VECTOR_ADDR = 32'hBFC0_0380,
  parameter int              FLUSH_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instr_valid,
  input  logic [31:0]       instr,
  input  logic [DATA_W-1:0] instr_pc,
  input  logic              in_delay_slot,
  input  logic              ovf_exc,
  input  logic              adel_exc,
  input  logic [DATA_W-1:0] bad_addr_in,
  input  logic              redirect_ready,
  output logic              flush,
  output logic              stall_req,
  output logic              redirect_valid,
  output logic [DATA_W-1:0] redirect_pc,
  output logic [DATA_W-1:0] epc,
  output logic [CODE_W-1:0] cause_code,
  output logic              cause_bd,
  output logic [DATA_W-1:0] bad_vaddr,
  output logic              exl
`ifdef TRAP_COUNT_EN
  ,
  output logic [15:0]       trap_count
`endif
);

  localparam logic [3:0] FLUSH_LD = 4'(FLUSH_CYCLES);

  trap_state_e state;
  trap_state_e state_nx;
  logic [3:0]  cnt;
  logic [3:0]  cnt_nx;

  logic             exc_pending;
  logic [EXC_W-1:0] exc_code;
  logic             is_eret;
  logic             take_trap;
  logic             take_eret;
  logic             exl_clr;

  trap_decode u_dec (
    .instr       (instr),
    .ovf_exc     (ovf_exc),
    .adel_exc    (adel_exc),
    .exc_pending (exc_pending),
    .exc_code    (exc_code),
    .is_eret     (is_eret)
  );

  // Exceptions are dropped while the handler runs (exl=1);
  // exl=1 also rules out a trap, so an ERET never races one.
  assign take_trap = (state == IDLE) && instr_valid
                   && exc_pending && !exl;
  assign take_eret = (state == IDLE) && instr_valid
                   && is_eret && exl;

  assign stall_req = (state != IDLE);

  always_comb begin
    state_nx       = state;
    cnt_nx         = cnt;
    flush          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    exl_clr        = 1'b0;
    unique case (state)
      IDLE: begin
        if (take_trap) begin
          state_nx = TRAP_FLUSH;
          cnt_nx   = FLUSH_LD;
        end else if (take_eret) begin
          state_nx = ERET_FLUSH;
          cnt_nx   = FLUSH_LD;
        end
      end
      TRAP_FLUSH: begin
        flush = 1'b1;
        if (cnt <= 4'd1) begin
          state_nx = TRAP_REDIR;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt - 4'd1;
        end
      end
      ERET_FLUSH: begin
        flush = 1'b1;
        if (cnt <= 4'd1) begin
          state_nx = ERET_REDIR;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt - 4'd1;
        end
      end
      TRAP_REDIR: begin
        redirect_valid = 1'b1;
        redirect_pc    = VECTOR_ADDR;
        if (redirect_ready)
          state_nx = IDLE;
      end
      ERET_REDIR: begin
        redirect_valid = 1'b1;
        redirect_pc    = epc;
        if (redirect_ready) begin
          state_nx = IDLE;
          exl_clr  = 1'b1;
        end
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // A delay-slot fault restarts at the branch, one word back.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      epc        <= '0;
      cause_code <= '0;
      cause_bd   <= 1'b0;
      bad_vaddr  <= '0;
      exl        <= 1'b0;
    end else begin
      if (take_trap) begin
        epc        <= in_delay_slot
                    ? instr_pc - DATA_W'(4)
                    : instr_pc;
        cause_code <= CODE_W'(exc_code);
        cause_bd   <= in_delay_slot;
        exl        <= 1'b1;
        if (adel_exc)
          bad_vaddr <= bad_addr_in;
      end else if (exl_clr) begin
        exl <= 1'b0;
      end
    end
  end

`ifdef TRAP_COUNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      trap_count <= '0;
    else if (take_trap && trap_count != 16'hFFFF)
      trap_count <= trap_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_trap_unit.sv
// Directed self-checking bench for trap_unit.
// Inputs driven on negedge, outputs sampled on negedge.
module tb_trap_unit;

  localparam logic [31:0] SYS  = 32'h0000_000C;
  localparam logic [31:0] BRK  = 32'h0000_000D;
  localparam logic [31:0] ERET = 32'h4200_0018;
  localparam logic [31:0] VEC  = 32'hBFC0_0380;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        in_delay_slot;
  logic        ovf_exc;
  logic        adel_exc;
  logic [31:0] bad_addr_in;
  logic        redirect_ready;
  logic        flush;
  logic        stall_req;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] epc;
  logic [5:0]  cause_code;
  logic        cause_bd;
  logic [31:0] bad_vaddr;
  logic        exl;
`ifdef TRAP_COUNT_EN
  logic [15:0] trap_count;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  trap_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .instr_valid    (instr_valid),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .in_delay_slot  (in_delay_slot),
    .ovf_exc        (ovf_exc),
    .adel_exc       (adel_exc),
    .bad_addr_in    (bad_addr_in),
    .redirect_ready (redirect_ready),
    .flush          (flush),
    .stall_req      (stall_req),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .epc            (epc),
    .cause_code     (cause_code),
    .cause_bd       (cause_bd),
    .bad_vaddr      (bad_vaddr),
    .exl            (exl)
`ifdef TRAP_COUNT_EN
    ,
    .trap_count     (trap_count)
`endif
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present one instruction for a single cycle; returns on the
  // negedge after the accepting edge.
  task automatic issue(input logic [31:0] i,
                       input logic [31:0] pc,
                       input logic ds,
                       input logic ov,
                       input logic ad,
                       input logic [31:0] ba);
    instr_valid   = 1'b1;
    instr         = i;
    instr_pc      = pc;
    in_delay_slot = ds;
    ovf_exc       = ov;
    adel_exc      = ad;
    bad_addr_in   = ba;
    @(negedge clk);
    instr_valid   = 1'b0;
    instr         = '0;
    in_delay_slot = 1'b0;
    ovf_exc       = 1'b0;
    adel_exc      = 1'b0;
  endtask

  // From first flush cycle with ready=1: flush x2, redirect x1.
  task automatic finish_redir();
    repeat (3) @(negedge clk);
  endtask

  task automatic do_eret(input string tag, input logic [31:0] exp_pc);
    issue(ERET, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    repeat (2) @(negedge clk);
    chk({tag, "_rpc"}, redirect_pc, exp_pc);
    @(negedge clk);
    chk({tag, "_exl"}, {31'b0, exl}, 32'd0);
  endtask

  initial begin
    rst_n          = 1'b0;
    instr_valid    = 1'b0;
    instr          = '0;
    instr_pc       = '0;
    in_delay_slot  = 1'b0;
    ovf_exc        = 1'b0;
    adel_exc       = 1'b0;
    bad_addr_in    = '0;
    redirect_ready = 1'b1;
    repeat (2) @(negedge clk);

    chk("rst_flush", {31'b0, flush}, 32'd0);
    chk("rst_stall", {31'b0, stall_req}, 32'd0);
    chk("rst_rv", {31'b0, redirect_valid}, 32'd0);
    chk("rst_rpc", redirect_pc, 32'd0);
    chk("rst_epc", epc, 32'd0);
    chk("rst_cause", {26'b0, cause_code}, 32'd0);
    chk("rst_exl", {31'b0, exl}, 32'd0);
`ifdef TRAP_COUNT_EN
    chk("rst_cnt", {16'b0, trap_count}, 32'd0);
`endif
    rst_n = 1'b1;
    @(negedge clk);

    // SYSCALL, not in delay slot
    issue(SYS, 32'h0040_0010, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("sys_cause", {26'b0, cause_code}, 32'd8);
    chk("sys_epc", epc, 32'h0040_0010);
    chk("sys_bd", {31'b0, cause_bd}, 32'd0);
    chk("sys_exl", {31'b0, exl}, 32'd1);
    chk("sys_fl1", {31'b0, flush}, 32'd1);
    chk("sys_stall", {31'b0, stall_req}, 32'd1);
    chk("sys_rv0", {31'b0, redirect_valid}, 32'd0);
    @(negedge clk);
    chk("sys_fl2", {31'b0, flush}, 32'd1);
    @(negedge clk);
    chk("sys_fl3", {31'b0, flush}, 32'd0);
    chk("sys_rv1", {31'b0, redirect_valid}, 32'd1);
    chk("sys_rpc", redirect_pc, VEC);
    @(negedge clk);
    chk("sys_idle", {31'b0, stall_req}, 32'd0);
    chk("sys_rvd", {31'b0, redirect_valid}, 32'd0);
    chk("sys_exl2", {31'b0, exl}, 32'd1);

    // second SYSCALL while exl=1 is ignored
    issue(SYS, 32'h0050_0000, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("ign_flush", {31'b0, flush}, 32'd0);
    chk("ign_stall", {31'b0, stall_req}, 32'd0);
    chk("ign_epc", epc, 32'h0040_0010);

    // ERET with ready held low for one extra cycle
    redirect_ready = 1'b0;
    issue(ERET, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("eret_fl1", {31'b0, flush}, 32'd1);
    @(negedge clk);
    chk("eret_fl2", {31'b0, flush}, 32'd1);
    @(negedge clk);
    chk("eret_rv", {31'b0, redirect_valid}, 32'd1);
    chk("eret_rpc", redirect_pc, 32'h0040_0010);
    chk("eret_exl1", {31'b0, exl}, 32'd1);
    @(negedge clk);
    chk("eret_exl2", {31'b0, exl}, 32'd1);
    redirect_ready = 1'b1;
    @(negedge clk);
    chk("eret_exl0", {31'b0, exl}, 32'd0);
    chk("eret_idle", {31'b0, stall_req}, 32'd0);

    // BREAK in delay slot
    issue(BRK, 32'h0040_0024, 1'b1, 1'b0, 1'b0, 32'h0);
    chk("bp_cause", {26'b0, cause_code}, 32'd9);
    chk("bp_bd", {31'b0, cause_bd}, 32'd1);
    chk("bp_epc", epc, 32'h0040_0020);
    finish_redir();
    do_eret("bp", 32'h0040_0020);

    // AdEL beats Ov beats Sys
    issue(SYS, 32'h0040_0030, 1'b0, 1'b1, 1'b1, 32'h0000_1003);
    chk("adel_cause", {26'b0, cause_code}, 32'd4);
    chk("adel_bad", bad_vaddr, 32'h0000_1003);
    finish_redir();
    do_eret("adel", 32'h0040_0030);

    issue(SYS, 32'h0040_0040, 1'b0, 1'b1, 1'b0, 32'h0000_DEAD);
    chk("ov_cause", {26'b0, cause_code}, 32'd12);
    chk("ov_bad", bad_vaddr, 32'h0000_1003);
    finish_redir();
    do_eret("ov", 32'h0040_0040);

    // EPC wraps below zero
    issue(SYS, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 32'h0);
    chk("wrap_epc", epc, 32'hFFFF_FFFC);
    finish_redir();
    do_eret("wrap", 32'hFFFF_FFFC);

    // ERET while exl=0 is a no-op
    issue(ERET, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("eret0_stall", {31'b0, stall_req}, 32'd0);
    chk("eret0_flush", {31'b0, flush}, 32'd0);

    // redirect back-pressure for 5 cycles
    redirect_ready = 1'b0;
    issue(BRK, 32'h0040_0050, 1'b0, 1'b0, 1'b0, 32'h0);
    repeat (2) @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      chk("bp_hold_rv", {31'b0, redirect_valid}, 32'd1);
      chk("bp_hold_rpc", redirect_pc, VEC);
      chk("bp_hold_stall", {31'b0, stall_req}, 32'd1);
      @(negedge clk);
    end
    redirect_ready = 1'b1;
    @(negedge clk);
    chk("bp_rel", {31'b0, stall_req}, 32'd0);

    // async reset mid-flush of an ERET
    issue(ERET, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("ar_pre", {31'b0, flush}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_flush", {31'b0, flush}, 32'd0);
    chk("ar_stall", {31'b0, stall_req}, 32'd0);
    chk("ar_exl", {31'b0, exl}, 32'd0);
    chk("ar_epc", epc, 32'd0);
    chk("ar_bad", bad_vaddr, 32'd0);
    chk("ar_cause", {26'b0, cause_code}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ar_after", {31'b0, stall_req}, 32'd0);

`ifdef TRAP_COUNT_EN
    issue(SYS, 32'h100, 1'b0, 1'b0, 1'b0, 32'h0);
    finish_redir();
    issue(SYS, 32'h200, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("cnt_ign", {31'b0, stall_req}, 32'd0);
    do_eret("c1", 32'h100);
    issue(BRK, 32'h300, 1'b0, 1'b0, 1'b0, 32'h0);
    finish_redir();
    do_eret("c2", 32'h300);
    issue(SYS, 32'h400, 1'b0, 1'b1, 1'b0, 32'h0);
    finish_redir();
    do_eret("c3", 32'h400);
    chk("cnt_3", {16'b0, trap_count}, 32'd3);
    force dut.trap_count = 16'hFFFF;
    @(negedge clk);
    release dut.trap_count;
    issue(SYS, 32'h500, 1'b0, 1'b0, 1'b0, 32'h0);
    finish_redir();
    chk("cnt_sat", {16'b0, trap_count}, 32'h0000_FFFF);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
